// File: rtl/adder_exhaustive_checker_pkg.sv
// adder_check_pkg: shared state encoding and golden-sum helper for the adder checker.
package adder_check_pkg;
    localparam int MAX_W = 32;

    typedef enum logic [1:0] {IDLE, APPLY, CHECK, DONE} state_t;

    // Callers zero-extend operands to MAX_W and truncate the result to WIDTH+1.
    function automatic logic [MAX_W:0] golden_sum(input logic [MAX_W-1:0] a, input logic [MAX_W-1:0] b);
        return {1'b0, a} + {1'b0, b};
    endfunction
endpackage

// File: rtl/adder_exhaustive_checker_if.sv
// adder_exhaustive_checker_if: operand/result bus and status bundle of the adder checker.
interface adder_exhaustive_checker_if #(
    parameter int WIDTH     = 7,
    parameter int ERR_CNT_W = 16
);
    logic                 i_start;
    logic [WIDTH-1:0]     o_add_term1;
    logic [WIDTH-1:0]     o_add_term2;
    logic [WIDTH:0]       i_result;
    logic                 o_busy;
    logic                 o_done;
    logic                 o_pass;
    logic [ERR_CNT_W-1:0] o_err_count;
    logic                 o_first_err_valid;
    logic [WIDTH-1:0]     o_first_err_term1;
    logic [WIDTH-1:0]     o_first_err_term2;
    logic [WIDTH:0]       o_first_err_result;

    modport master (
        input  i_start, i_result,
        output o_add_term1, o_add_term2, o_busy, o_done, o_pass, o_err_count,
               o_first_err_valid, o_first_err_term1, o_first_err_term2, o_first_err_result
    );

    modport slave (
        output i_start, i_result,
        input  o_add_term1, o_add_term2, o_busy, o_done, o_pass, o_err_count,
               o_first_err_valid, o_first_err_term1, o_first_err_term2, o_first_err_result
    );
endinterface

// File: rtl/adder_exhaustive_checker_vector_gen.sv
// adder_vector_gen: operand pair register walking all pairs, term1 fastest.
module adder_vector_gen #(
    parameter int WIDTH = 7
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             clear,
    input  logic             advance,
    output logic [WIDTH-1:0] term1,
    output logic [WIDTH-1:0] term2,
    output logic             last
);
    assign last = &{term2, term1};

    // Treating the pair as one 2*WIDTH counter gives the term2 carry on term1 wrap for free.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            term1 <= '0;
            term2 <= '0;
        end else if (clear) begin
            term1 <= '0;
            term2 <= '0;
        end else if (advance) begin
            {term2, term1} <= {term2, term1} + (2*WIDTH)'(1);
        end
    end
endmodule

// File: rtl/adder_exhaustive_checker.sv
// adder_exhaustive_checker: sweeps every operand pair through an external adder and
// records pass/fail, a saturating mismatch count and the first failing vector.
module adder_exhaustive_checker
    import adder_check_pkg::*;
#(
    parameter int WIDTH     = 7,
    parameter int SETTLE    = 2,
    parameter int ERR_CNT_W = 16
) (
    input logic                  i_clk,
    input logic                  i_rst_n,
    adder_exhaustive_checker_if.master bus
);
    localparam int SW = SETTLE > 1 ? $clog2(SETTLE) : 1;

    state_t               state;
    logic [SW-1:0]        settle_cnt;
    logic [WIDTH-1:0]     term1;
    logic [WIDTH-1:0]     term2;
    logic                 last;
    logic [WIDTH:0]       golden;
    logic                 mismatch;
    logic                 accept;
    logic                 busy;
    logic                 done;
    logic                 pass;
    logic [ERR_CNT_W-1:0] err_count;
    logic                 fe_valid;
    logic [WIDTH-1:0]     fe_term1;
    logic [WIDTH-1:0]     fe_term2;
    logic [WIDTH:0]       fe_result;

    assign accept   = bus.i_start && (state == IDLE || state == DONE);
    assign golden   = (WIDTH+1)'(golden_sum(MAX_W'(term1), MAX_W'(term2)));
    assign mismatch = bus.i_result != golden;

    adder_vector_gen #(.WIDTH(WIDTH)) u_vector_gen (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .clear   (accept),
        .advance (state == CHECK && !last),
        .term1   (term1),
        .term2   (term2),
        .last    (last)
    );

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state      <= IDLE;
            settle_cnt <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
            pass       <= 1'b0;
            err_count  <= '0;
            fe_valid   <= 1'b0;
            fe_term1   <= '0;
            fe_term2   <= '0;
            fe_result  <= '0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (accept) begin
                        state      <= APPLY;
                        settle_cnt <= '0;
                        busy       <= 1'b1;
                        done       <= 1'b0;
                        pass       <= 1'b0;
                        err_count  <= '0;
                        fe_valid   <= 1'b0;
                        fe_term1   <= '0;
                        fe_term2   <= '0;
                        fe_result  <= '0;
                    end
                end
                APPLY: begin
                    settle_cnt <= settle_cnt == SW'(SETTLE-1) ? '0 : settle_cnt + SW'(1);
                    if (settle_cnt == SW'(SETTLE-1)) state <= CHECK;
                end
                CHECK: begin
                    if (mismatch && err_count != {ERR_CNT_W{1'b1}}) err_count <= err_count + ERR_CNT_W'(1);
                    if (mismatch && !fe_valid) begin
                        fe_valid  <= 1'b1;
                        fe_term1  <= term1;
                        fe_term2  <= term2;
                        fe_result <= bus.i_result;
                    end
                    // The count register still lags this cycle's compare, so fold it in here.
                    if (last) begin
                        state <= DONE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        pass  <= err_count == '0 && !mismatch;
                    end else begin
                        state <= APPLY;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.o_add_term1        = term1;
    assign bus.o_add_term2        = term2;
    assign bus.o_busy             = busy;
    assign bus.o_done             = done;
    assign bus.o_pass             = pass;
    assign bus.o_err_count        = err_count;
    assign bus.o_first_err_valid  = fe_valid;
    assign bus.o_first_err_term1  = fe_term1;
    assign bus.o_first_err_term2  = fe_term2;
    assign bus.o_first_err_result = fe_result;
endmodule

// File: tb/tb_adder_exhaustive_checker.sv
// tb_adder_exhaustive_checker: directed sweeps against a faultable behavioural adder,
// with expected results derived by enumerating all operand pairs in the bench.
module tb_adder_exhaustive_checker;
    localparam int W = 4;
    localparam int S = 2;
    localparam int E = 6;
    localparam int N = 1 << (2*W);
    localparam int SWEEP = N * (S + 1);

    logic clk = 1'b0;
    logic rst_n;
    int   mode;
    logic [N-1:0] bad_vec;
    int   checks = 0;
    int   errors = 0;

    adder_exhaustive_checker_if #(.WIDTH(W), .ERR_CNT_W(E)) bus ();

    adder_exhaustive_checker #(.WIDTH(W), .SETTLE(S), .ERR_CNT_W(E)) dut (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    // Mode 0 ideal, 1 sum MSB stuck at 0, 2 sum stuck at 0, 3 LSB flipped on selected vectors.
    function automatic logic [W:0] adder_model(input int m, input logic [N-1:0] bad,
                                               input logic [W-1:0] a, input logic [W-1:0] b);
        logic [W:0] s;
        s = {1'b0, a} + {1'b0, b};
        case (m)
            1:       return {1'b0, s[W-1:0]};
            2:       return '0;
            3:       return s ^ {{W{1'b0}}, bad[{b, a}]};
            default: return s;
        endcase
    endfunction

    assign bus.i_result = adder_model(mode, bad_vec, bus.o_add_term1, bus.o_add_term2);

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s got %0h exp %0h", tag, got, exp);
        end
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, " term1"}, 32'(bus.o_add_term1), 0);
        chk({tag, " term2"}, 32'(bus.o_add_term2), 0);
        chk({tag, " busy"}, 32'(bus.o_busy), 0);
        chk({tag, " done"}, 32'(bus.o_done), 0);
        chk({tag, " pass"}, 32'(bus.o_pass), 0);
        chk({tag, " err_count"}, 32'(bus.o_err_count), 0);
        chk({tag, " fe_valid"}, 32'(bus.o_first_err_valid), 0);
        chk({tag, " fe_term1"}, 32'(bus.o_first_err_term1), 0);
        chk({tag, " fe_term2"}, 32'(bus.o_first_err_term2), 0);
        chk({tag, " fe_result"}, 32'(bus.o_first_err_result), 0);
    endtask

    task automatic run(input int m, input bit mid_start);
        int cnt, k, fa, fb, fr;
        bit fv;
        mode = m;
        cnt = 0; fv = 0; fa = 0; fb = 0; fr = 0;
        for (int v = 0; v < N; v++) begin
            int a, b, r;
            a = v % (1 << W);
            b = v / (1 << W);
            r = int'(adder_model(m, bad_vec, W'(a), W'(b)));
            if (r != a + b) begin
                cnt++;
                if (!fv) begin fv = 1; fa = a; fb = b; fr = r; end
            end
        end
        bus.i_start = 1'b1;
        tick();
        bus.i_start = 1'b0;
        chk("start busy", 32'(bus.o_busy), 1);
        chk("start done", 32'(bus.o_done), 0);
        chk("start err_count", 32'(bus.o_err_count), 0);
        chk("start fe_valid", 32'(bus.o_first_err_valid), 0);
        k = 0;
        while (!bus.o_done && k <= SWEEP + 8) begin
            chk("busy_done_excl", 32'(bus.o_busy && bus.o_done), 0);
            chk("seq term1", 32'(bus.o_add_term1), 32'((k / (S + 1)) % (1 << W)));
            chk("seq term2", 32'(bus.o_add_term2), 32'((k / (S + 1)) / (1 << W)));
            bus.i_start = mid_start && k == 50;
            tick();
            k++;
        end
        bus.i_start = 1'b0;
        chk("sweep cycles", 32'(k), 32'(SWEEP));
        chk("end done", 32'(bus.o_done), 1);
        chk("end busy", 32'(bus.o_busy), 0);
        chk("end pass", 32'(bus.o_pass), 32'(cnt == 0));
        chk("end err_count", 32'(bus.o_err_count), 32'(cnt > (1 << E) - 1 ? (1 << E) - 1 : cnt));
        chk("end fe_valid", 32'(bus.o_first_err_valid), 32'(fv));
        chk("end fe_term1", 32'(bus.o_first_err_term1), 32'(fa));
        chk("end fe_term2", 32'(bus.o_first_err_term2), 32'(fb));
        chk("end fe_result", 32'(bus.o_first_err_result), 32'(fr));
        tick();
        chk("held done", 32'(bus.o_done), 1);
        chk("held err_count", 32'(bus.o_err_count), 32'(cnt > (1 << E) - 1 ? (1 << E) - 1 : cnt));
    endtask

    initial begin
        rst_n = 1'b0;
        bus.i_start = 1'b0;
        mode = 0;
        bad_vec = '0;
        for (int i = 0; i < N; i++) bad_vec[i] = $urandom_range(0, 11) == 0;
        bad_vec[$urandom_range(0, N-1)] = 1'b1;
        tick();
        tick();
        chk_zero("reset");
        rst_n = 1'b1;
        tick();
        chk_zero("idle");
        run(0, 0);
        run(1, 0);
        run(2, 0);
        run(0, 0);
        run(3, 1);
        mode = 2;
        bus.i_start = 1'b1;
        tick();
        bus.i_start = 1'b0;
        repeat (200) tick();
        chk("pre-reset err_count nonzero", 32'(bus.o_err_count != 0), 1);
        #2;
        rst_n = 1'b0;
        #1;
        chk_zero("async reset");
        tick();
        rst_n = 1'b1;
        tick();
        run(0, 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
